// File: rtl/cp_xf_pkg.sv
// -----------------------------------------------------------------------------
// cp_xf_pkg
// Shared constants and types for the CP-side XF register/matrix loader.
//   - GX command opcodes understood by the loader
//   - Loader FSM state type
//   - XF region-select codes carried in CPAddr[15:12]
//   - region_ok(): true when an address targets a region XF accepts writes to
// No ports (package).
// -----------------------------------------------------------------------------
package cp_xf_pkg;

    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [7:0] OP_LOAD_XF_REG = 8'h10;

    localparam logic [3:0] REGION_MATRIX  = 4'h0;
    localparam logic [3:0] REGION_CONTROL = 4'h1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    function automatic logic region_ok(input logic [15:0] addr);
        return (addr[15:12] == REGION_MATRIX) || (addr[15:12] == REGION_CONTROL);
    endfunction

endpackage

// File: rtl/cp_word_assembler.sv
// -----------------------------------------------------------------------------
// cp_word_assembler
// Collects four consecutive accepted bytes into one big-endian 32-bit word.
// The fourth byte is not stored: it is combined straight from byte_i so the
// word is available in the same cycle as its last handshake (done_o).
// Ports:
//   clk     in   clock
//   reset   in   synchronous active-high reset (clears byte index)
//   en_i    in   a byte is accepted this cycle
//   byte_i  in   accepted byte
//   word_o  out  assembled word {b0,b1,b2,b3}, valid while done_o is high
//   done_o  out  high in the cycle the fourth byte is accepted
// -----------------------------------------------------------------------------
module cp_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        done_o
);

    logic [1:0] idx_q;
    logic [1:0] idx_d;
    logic [7:0] lane_q [3];

    assign idx_d = en_i ? idx_q + 2'd1 : idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= 2'd0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // One capture register per leading byte lane; lane gi loads when the
    // byte index points at it.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        always_ff @(posedge clk) begin
            if (reset) begin
                lane_q[gi] <= 8'h00;
            end else if (en_i && (idx_q == 2'(gi))) begin
                lane_q[gi] <= byte_i;
            end
        end
    end

    assign done_o = en_i && (idx_q == 2'd3);
    assign word_o = {lane_q[0], lane_q[1], lane_q[2], byte_i};

endmodule

// File: rtl/cp_xf_loader.sv
// -----------------------------------------------------------------------------
// cp_xf_loader
// Decodes LOAD_XF_REG packets from the GX command byte stream and issues one
// XF write per 32-bit payload word with an auto-incrementing 16-bit address.
// XF cannot stall, so the FIFO is always drained (FifoReady high outside reset).
//
// Packet: 0x10 | header H (4 bytes BE: H[31:16]=count-1, H[15:0]=base) |
//         (count) x data word (4 bytes BE)
//
// Optional build macro:
//   CP_XF_RANGE_CHECK_EN - words aimed outside the matrix/control regions are
//                          dropped and flagged on CmdError instead of written.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous active-high reset
//   FifoData     in   command byte
//   FifoValid    in   FifoData valid
//   FifoReady    out  byte accepted when FifoValid & FifoReady
//   CPAddr       out  XF address of the last write (held between strobes)
//   CPWrite      out  single-cycle write strobe
//   CPWriteData  out  data of the last write (held between strobes)
//   Busy         out  LOAD_XF_REG packet in progress
//   CmdError     out  single-cycle pulse: bad opcode (or out-of-range word)
// -----------------------------------------------------------------------------
module cp_xf_loader
    import cp_xf_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  FifoData,
    input  logic        FifoValid,
    output logic        FifoReady,
    output logic [15:0] CPAddr,
    output logic        CPWrite,
    output logic [31:0] CPWriteData,
    output logic        Busy,
    output logic        CmdError
);

    state_e      state_q,    state_d;
    logic [15:0] addr_q,     addr_d;
    logic [15:0] remain_q,   remain_d;
    logic [15:0] cp_addr_q,  cp_addr_d;
    logic [31:0] cp_wdata_q, cp_wdata_d;
    logic        cp_write_q, cp_write_d;
    logic        busy_q,     busy_d;
    logic        err_q,      err_d;
    logic        final_word;

    logic        accept;
    logic        asm_en;
    logic [31:0] asm_word;
    logic        asm_done;

    assign FifoReady = ~reset;
    assign accept    = FifoValid & FifoReady;
    // Opcode bytes are consumed in IDLE and never reach the assembler.
    assign asm_en    = accept && (state_q != ST_IDLE);

    cp_word_assembler u_asm (
        .clk    (clk),
        .reset  (reset),
        .en_i   (asm_en),
        .byte_i (FifoData),
        .word_o (asm_word),
        .done_o (asm_done)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        cp_addr_d  = cp_addr_q;
        cp_wdata_d = cp_wdata_q;
        cp_write_d = 1'b0;
        err_d      = 1'b0;
        final_word = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (FifoData == OP_LOAD_XF_REG) begin
                        state_d = ST_HDR;
                    end else if (FifoData != OP_NOP) begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_HDR: begin
                if (asm_done) begin
                    addr_d   = asm_word[15:0];
                    remain_d = asm_word[31:16];
                    state_d  = ST_DATA;
                end
            end

            ST_DATA: begin
                if (asm_done) begin
`ifdef CP_XF_RANGE_CHECK_EN
                    if (region_ok(addr_q)) begin
                        cp_write_d = 1'b1;
                        cp_addr_d  = addr_q;
                        cp_wdata_d = asm_word;
                    end else begin
                        err_d = 1'b1;
                    end
`else
                    cp_write_d = 1'b1;
                    cp_addr_d  = addr_q;
                    cp_wdata_d = asm_word;
`endif
                    addr_d = addr_q + 16'd1;
                    if (remain_q == 16'd0) begin
                        final_word = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        remain_d = remain_q - 16'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Busy covers the strobe cycle of the final word even though the FSM
        // is already back in IDLE then.
        busy_d = (state_d != ST_IDLE) || final_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= 16'h0000;
            remain_q   <= 16'h0000;
            cp_addr_q  <= 16'h0000;
            cp_wdata_q <= 32'h0000_0000;
            cp_write_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            cp_addr_q  <= cp_addr_d;
            cp_wdata_q <= cp_wdata_d;
            cp_write_q <= cp_write_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign CPAddr      = cp_addr_q;
    assign CPWrite     = cp_write_q;
    assign CPWriteData = cp_wdata_q;
    assign Busy        = busy_q;
    assign CmdError    = err_q;

endmodule

// File: tb/tb_cp_xf_loader.sv
module tb_cp_xf_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  FifoData;
    logic        FifoValid;
    logic        FifoReady;
    logic [15:0] CPAddr;
    logic        CPWrite;
    logic [31:0] CPWriteData;
    logic        Busy;
    logic        CmdError;

    cp_xf_loader dut (
        .clk         (clk),
        .reset       (reset),
        .FifoData    (FifoData),
        .FifoValid   (FifoValid),
        .FifoReady   (FifoReady),
        .CPAddr      (CPAddr),
        .CPWrite     (CPWrite),
        .CPWriteData (CPWriteData),
        .Busy        (Busy),
        .CmdError    (CmdError)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    typedef struct {
        bit          is_err;
        logic [15:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  wtime_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Monitor: every DUT-visible event pops one expectation in stream order.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (CPWrite === 1'b1) begin
                wtime_q.push_back(cycle);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no event", CPAddr, CPWriteData);
                end else begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    check("event_kind_write", 64'(ev.is_err), 64'd0);
                    check("write_addr", 64'(CPAddr), 64'(ev.addr));
                    check("write_data", 64'(CPWriteData), 64'(ev.data));
                    $display("write addr=0x%04h data=0x%08h", CPAddr, CPWriteData);
                end
            end
            if (CmdError === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmderror: got CmdError 1, expected no event");
                end else begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    check("event_kind_error", 64'(ev.is_err), 64'd1);
                    $display("cmd_error");
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    // ---------------- driver / reference model ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        FifoValid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        FifoData  = b;
        FifoValid = 1'b1;
        @(posedge clk);
        #1;
        FifoValid = 1'b0;
    endtask

    function automatic int pick_gap(input int maxgap);
        if (maxgap == 0) return 0;
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(1, maxgap));
        return 0;
    endfunction

    function automatic bit addr_rejected(input logic [15:0] a);
`ifdef CP_XF_RANGE_CHECK_EN
        return a[15:12] > 4'd1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic send_word(input logic [31:0] w, input int maxgap);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(v[31:24], pick_gap(maxgap));
            v = v << 8;
        end
    endtask

    // Model: packet with (cnt_m1+1) words from base; word k goes to base+k
    // modulo 2^16 unless its region is rejected.
    task automatic load_packet(input logic [15:0] base, input logic [15:0] cnt_m1,
                               input bit use_fixed, input logic [31:0] d0, input int maxgap);
        logic [15:0] a;
        logic [31:0] d;
        ev_t         ev;
        a = base;
        send_byte(8'h10, pick_gap(maxgap));
        send_word({cnt_m1, base}, maxgap);
        for (int w = 0; w <= int'(cnt_m1); w++) begin
            d = use_fixed ? d0 + 32'(w) : $urandom;
            ev.is_err = addr_rejected(a);
            ev.addr   = a;
            ev.data   = d;
            exp_q.push_back(ev);
            a = a + 16'd1;
            send_word(d, maxgap);
        end
    endtask

    task automatic bad_opcode(input logic [7:0] op, input int gap);
        ev_t ev;
        ev.is_err = 1'b1;
        ev.addr   = 16'h0;
        ev.data   = 32'h0;
        exp_q.push_back(ev);
        send_byte(op, gap);
    endtask

    initial begin
        int n0;
        int waited;
        ev_t ev;

        reset     = 1'b1;
        FifoValid = 1'b0;
        FifoData  = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_fifo_ready", 64'(FifoReady), 64'd0);
        check("reset_cpaddr", 64'(CPAddr), 64'd0);
        check("reset_cpwrite", 64'(CPWrite), 64'd0);
        check("reset_cpwdata", 64'(CPWriteData), 64'd0);
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_cmderror", 64'(CmdError), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", 64'(FifoReady), 64'd1);

        // Single word load: strobe one cycle after 4th data byte, Busy ends after.
        load_packet(16'h0020, 16'h0000, 1'b1, 32'h3F80_0000, 0);
        check("t1_cpwrite_latency", 64'(CPWrite), 64'd1);
        check("t1_busy_in_strobe", 64'(Busy), 64'd1);
        @(posedge clk);
        #1;
        check("t1_busy_after", 64'(Busy), 64'd0);
        check("t1_cpwrite_single", 64'(CPWrite), 64'd0);
        check("t1_cpaddr_held", 64'(CPAddr), 64'h0020);

        // Three words back to back: 4-cycle spacing.
        n0 = wtime_q.size();
        load_packet(16'h1000, 16'h0002, 1'b1, 32'hA000_0000, 0);
        @(negedge clk);
        #1;
        check("t2_write_count", 64'(wtime_q.size() - n0), 64'd3);
        if (wtime_q.size() - n0 == 3) begin
            check("t2_spacing_01", 64'(wtime_q[n0+1] - wtime_q[n0]), 64'd4);
            check("t2_spacing_12", 64'(wtime_q[n0+2] - wtime_q[n0+1]), 64'd4);
        end

        // Address wrap.
        load_packet(16'hFFFF, 16'h0001, 1'b0, 32'h0, 0);

        // NOP silent, bad opcode flagged, then a normal packet.
        send_byte(8'h00, 1);
        check("t4_nop_no_error", 64'(CmdError), 64'd0);
        check("t4_nop_not_busy", 64'(Busy), 64'd0);
        bad_opcode(8'h61, 0);
        check("t4_bad_op_pulse", 64'(CmdError), 64'd1);
        load_packet(16'h0100, 16'h0001, 1'b0, 32'h0, 0);

        // FifoValid dropped for 5 cycles between data bytes 2 and 3.
        send_byte(8'h10, 0);
        send_word(32'h0000_0040, 0);
        ev.is_err = 1'b0;
        ev.addr   = 16'h0040;
        ev.data   = 32'hDEAD_BEEF;
        exp_q.push_back(ev);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 5);
        check("t5_no_early_write", 64'(CPWrite), 64'd0);
        send_byte(8'hEF, 0);
        check("t5_delayed_write", 64'(CPWrite), 64'd1);
        check("t5_delayed_data", 64'(CPWriteData), 64'hDEAD_BEEF);

        // Reset after two data bytes: packet abandoned.
        send_byte(8'h10, 0);
        send_word(32'h0000_0050, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_reset_busy", 64'(Busy), 64'd0);
        check("t6_reset_ready", 64'(FifoReady), 64'd0);
        reset = 1'b0;
        load_packet(16'h0060, 16'h0000, 1'b1, 32'h1234_5678, 0);
        check("t6_after_reset_write", 64'(CPWrite), 64'd1);

        // Region outside matrix/control.
        load_packet(16'h2000, 16'h0000, 1'b1, 32'h5555_AAAA, 0);
`ifdef CP_XF_RANGE_CHECK_EN
        check("t7_range_no_write", 64'(CPWrite), 64'd0);
        check("t7_range_error", 64'(CmdError), 64'd1);
`else
        check("t7_write_any_region", 64'(CPWrite), 64'd1);
        check("t7_addr_2000", 64'(CPAddr), 64'h2000);
`endif

        // Randomized mix of NOPs, bad opcodes and loads with random gaps.
        for (int k = 0; k < 40; k++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                send_byte(8'h00, pick_gap(3));
            end else if (sel == 1) begin
                logic [7:0] op;
                op = 8'($urandom_range(1, 255));
                if (op == 8'h10) op = 8'hFF;
                bad_opcode(op, pick_gap(3));
            end else begin
                load_packet(16'($urandom), 16'($urandom_range(0, 5)), 1'b0, 32'h0, 3);
            end
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        @(negedge clk);
        #1;
        check("drain_expected_empty", 64'(exp_q.size()), 64'd0);
        check("final_not_busy", 64'(Busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
